clock_timekeeper: RTL

- Consumes the slow square wave `tick_in` produced by the programmable clock divider.
- Synchronises `tick_in` into the `clk` domain and detects its rising edges.
- Prescales the edges to one-second increments.
- Maintains a BCD hours:minutes:seconds time-of-day with a manual set mode; outputs feed the seven-segment display logic.

---
 rtl/clock_timekeeper.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/clock_timekeeper.sv
// clock_timekeeper: synchronises the divided tick, prescales it to seconds and
// keeps a BCD hh:mm:ss time-of-day with a manual set mode.
// Optional feature macro: TIMEKEEPER_12H_EN (12-hour display with pm flag).
module clock_timekeeper #(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned TICKS_PER_SEC = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_in,
   input  logic       set_en,
   input  logic       inc_min,
   input  logic       inc_hour,
   output logic [7:0] sec_bcd,
   output logic [7:0] min_bcd,
   output logic [7:0] hour_bcd,
   output logic       pm,
   output logic       tick_pulse,
   output logic       sec_pulse,
   output logic       day_wrap
);

   localparam int unsigned PW        = 7;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [7:0]  SEC_MAX   = 8'h59;
   localparam logic [7:0]  MIN_MAX   = 8'h59;
   localparam logic [7:0]  HOUR_MAX  = 8'h23;

   // BCD increment with wrap to 00 once the limit is reached
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
      logic [7:0] r;
      if (v == lim)
         r = 8'h00;
      else if (v[3:0] == 4'd9)
         r = {v[7:4] + 4'd1, 4'd0};
      else
         r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] vld_q;
   logic                   prev_q;
   logic                   armed_q;
   logic                   sync_lvl;
   logic                   tick_det;

   logic [PW-1:0] presc_q;
   logic [PW-1:0] presc_nxt;
   logic [7:0]    hour_q;
   logic [7:0]    sec_nxt;
   logic [7:0]    min_nxt;
   logic [7:0]    hour_nxt;
   logic          sec_inc;
   logic          day_wrap_nxt;

   assign sync_lvl = sync_q[SYNC_STAGES-1];
   assign tick_det = sync_lvl & ~prev_q & armed_q;

   // Synchroniser chain plus a matching valid chain so reset-state zeros never arm the detector
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         vld_q  <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
         vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   // Rising-edge detector, armed once a genuine low level has been observed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q     <= 1'b0;
         armed_q    <= 1'b0;
         tick_pulse <= 1'b0;
      end else begin
         prev_q     <= sync_lvl;
         armed_q    <= armed_q | (vld_q[SYNC_STAGES-1] & ~sync_lvl);
         tick_pulse <= tick_det;
      end
   end

   // Next-state for prescaler and time-of-day; set mode has priority over counting
   always_comb begin
      presc_nxt    = presc_q;
      sec_nxt      = sec_bcd;
      min_nxt      = min_bcd;
      hour_nxt     = hour_q;
      sec_inc      = 1'b0;
      day_wrap_nxt = 1'b0;
      if (set_en) begin
         presc_nxt = '0;
         sec_nxt   = 8'h00;
         if (inc_min)
            min_nxt = bcd_inc(min_bcd, MIN_MAX);
         if (inc_hour)
            hour_nxt = bcd_inc(hour_q, HOUR_MAX);
      end else if (tick_pulse) begin
         if (presc_q == PRE_LAST) begin
            presc_nxt = '0;
            sec_inc   = 1'b1;
            sec_nxt   = bcd_inc(sec_bcd, SEC_MAX);
            if (sec_bcd == SEC_MAX) begin
               min_nxt = bcd_inc(min_bcd, MIN_MAX);
               if (min_bcd == MIN_MAX) begin
                  hour_nxt = bcd_inc(hour_q, HOUR_MAX);
                  if (hour_q == HOUR_MAX)
                     day_wrap_nxt = 1'b1;
               end
            end
         end else begin
            presc_nxt = presc_q + PW'(1);
         end
      end
   end

   // Time-of-day, prescaler and strobe registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q   <= '0;
         sec_bcd   <= 8'h00;
         min_bcd   <= 8'h00;
         hour_q    <= 8'h00;
         sec_pulse <= 1'b0;
         day_wrap  <= 1'b0;
      end else begin
         presc_q   <= presc_nxt;
         sec_bcd   <= sec_nxt;
         min_bcd   <= min_nxt;
         hour_q    <= hour_nxt;
         sec_pulse <= sec_inc;
         day_wrap  <= day_wrap_nxt;
      end
   end

`ifdef TIMEKEEPER_12H_EN
   // Map internal 24-hour BCD to 12-hour display BCD
   function automatic logic [7:0] to_12h(input logic [7:0] h);
      logic [7:0] r;
      case (h)
         8'h00:   r = 8'h12;
         8'h13:   r = 8'h01;
         8'h14:   r = 8'h02;
         8'h15:   r = 8'h03;
         8'h16:   r = 8'h04;
         8'h17:   r = 8'h05;
         8'h18:   r = 8'h06;
         8'h19:   r = 8'h07;
         8'h20:   r = 8'h08;
         8'h21:   r = 8'h09;
         8'h22:   r = 8'h10;
         8'h23:   r = 8'h11;
         default: r = h;
      endcase
      return r;
   endfunction

   // Registered 12-hour display and afternoon flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hour_bcd <= 8'h00;
         pm       <= 1'b0;
      end else begin
         hour_bcd <= to_12h(hour_nxt);
         pm       <= (hour_nxt >= 8'h12);
      end
   end
`else
   assign hour_bcd = hour_q;
   assign pm       = 1'b0;
`endif

endmodule
